// File: rtl/turfio_cout_cmdgen.sv
// COUT command word generator: training/guard/run sequencing plus a trigger FIFO
// that merges run commands, triggers and messages into one 32-bit word per cycle.
module turfio_cout_cmdgen #(
  parameter int TRIG_FIFO_DEPTH = 4,
  parameter int GUARD_WORDS     = 2
) (
  input  logic        if_clk_i,
  input  logic        if_rst_i,
  input  logic        sync_i,
  input  logic        train_req_i,
  input  logic        trig_i,
  input  logic [11:0] trig_word_i,
  input  logic        run_valid_i,
  output logic        run_ready_o,
  input  logic [3:0]  run_cmd_i,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  input  logic [15:0] msg_data_i,
  input  logic        ovf_clr_i,
  output logic [31:0] cout_command_o,
  output logic        cout_train_o,
  output logic        trig_overflow_o,
  output logic [15:0] trig_count_o,
  output logic [1:0]  dbg_state
);

  localparam int AW = (TRIG_FIFO_DEPTH > 1) ? $clog2(TRIG_FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_TRAIN     = 2'd0,
    ST_EXIT_WAIT = 2'd1,
    ST_GUARD     = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  guard_cnt, guard_cnt_nxt;

  logic [11:0] fifo_mem [TRIG_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic          push, pop, ovf_evt;
  logic          run_acc, msg_acc;
  logic [31:0]   cmd_nxt;

  // Handshakes: a transfer happens at a rising edge where valid and ready are
  // both 1; ready is high exactly while the FSM sits in RUN, and valid may
  // be held or dropped freely by the source.
  assign run_ready_o  = (state == ST_RUN);
  assign msg_ready_o  = (state == ST_RUN);
  assign run_acc      = run_valid_i & run_ready_o;
  assign msg_acc      = msg_valid_i & msg_ready_o;
  assign cout_train_o = (state == ST_TRAIN) || (state == ST_EXIT_WAIT);
  assign dbg_state    = state;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(TRIG_FIFO_DEPTH));
  assign pop        = (state == ST_RUN) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = trig_i && (!fifo_full || pop);
  assign ovf_evt    = trig_i && fifo_full && !pop;

  always_comb begin
    state_nxt     = state;
    guard_cnt_nxt = guard_cnt;
    case (state)
      ST_TRAIN: begin
        if (!train_req_i) state_nxt = ST_EXIT_WAIT;
      end
      ST_EXIT_WAIT: begin
        if (train_req_i) begin
          state_nxt = ST_TRAIN;
        end else if (sync_i) begin
          state_nxt     = ST_GUARD;
          guard_cnt_nxt = '0;
        end
      end
      ST_GUARD: begin
        if (guard_cnt == 4'(GUARD_WORDS - 1)) state_nxt = ST_RUN;
        else guard_cnt_nxt = guard_cnt + 4'd1;
      end
      ST_RUN: begin
        if (train_req_i && sync_i) state_nxt = ST_TRAIN;
      end
      default: state_nxt = ST_TRAIN;
    endcase
  end

  always_comb begin
    cmd_nxt = '0;
    if (state == ST_RUN) begin
      cmd_nxt = {run_acc ? run_cmd_i : 4'h0,
                 pop ? fifo_mem[rd_ptr] : 12'h0,
                 msg_acc ? msg_data_i : 16'h0};
    end
  end

  always_ff @(posedge if_clk_i or posedge if_rst_i) begin
    if (if_rst_i) begin
      state          <= ST_TRAIN;
      guard_cnt      <= '0;
      cout_command_o <= '0;
    end else begin
      state          <= state_nxt;
      guard_cnt      <= guard_cnt_nxt;
      cout_command_o <= cmd_nxt;
    end
  end

  always_ff @(posedge if_clk_i or posedge if_rst_i) begin
    if (if_rst_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      trig_overflow_o <= 1'b0;
      trig_count_o    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        trig_count_o <= trig_count_o + 16'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      // A new drop outranks a clear in the same cycle.
      if (ovf_evt)        trig_overflow_o <= 1'b1;
      else if (ovf_clr_i) trig_overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge if_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= trig_word_i;
  end

endmodule

// File: tb/tb_turfio_cout_cmdgen.sv
// Bench for turfio_cout_cmdgen: training exit timing, word merging, trigger
// FIFO overflow and drain, train re-entry and mid-run reset.
module tb_turfio_cout_cmdgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_i, train_req, trig, run_valid, msg_valid, ovf_clr;
  logic [11:0] trig_word;
  logic [3:0]  run_cmd;
  logic [15:0] msg_data;
  logic        run_ready, msg_ready, cout_train, trig_overflow;
  logic [31:0] cout_command;
  logic [15:0] trig_count;
  logic [1:0]  dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          phase   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_count = '0;

  turfio_cout_cmdgen #(.TRIG_FIFO_DEPTH(4), .GUARD_WORDS(2)) dut (
    .if_clk_i(clk), .if_rst_i(rst), .sync_i(sync_i), .train_req_i(train_req),
    .trig_i(trig), .trig_word_i(trig_word),
    .run_valid_i(run_valid), .run_ready_o(run_ready), .run_cmd_i(run_cmd),
    .msg_valid_i(msg_valid), .msg_ready_o(msg_ready), .msg_data_i(msg_data),
    .ovf_clr_i(ovf_clr), .cout_command_o(cout_command), .cout_train_o(cout_train),
    .trig_overflow_o(trig_overflow), .trig_count_o(trig_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sync_i pulses every 8 edges from the bench phase counter.
  task automatic tick();
    @(posedge clk);
    #1;
    phase++;
    sync_i = (phase % 8 == 7);
  endtask

  task automatic idle_inputs();
    trig = 0; trig_word = '0; run_valid = 0; run_cmd = '0;
    msg_valid = 0; msg_data = '0; ovf_clr = 0;
  endtask

  // Leave training and walk through the guard words up to the first RUN cycle.
  task automatic bring_up();
    bit seen = 0;
    bit s;
    train_req = 0; phase = 0; sync_i = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      s = sync_i;
      if (s) check_val("train_pre_sync", cout_train, 1'b1);
      tick();
      if (s) seen = 1;
    end
    check_val("train_drop", cout_train, 1'b0);
    check_val("guard0_cmd", cout_command, 32'h0);
    check_val("guard0_ready", run_ready, 1'b0);
    tick();
    check_val("guard1_cmd", cout_command, 32'h0);
    check_val("guard1_ready", run_ready, 1'b0);
    tick();
    check_val("run_ready_rise", run_ready, 1'b1);
    check_val("msg_ready_rise", msg_ready, 1'b1);
  endtask

  task automatic wait_sync_edge();
    bit s;
    for (int i = 0; i < 16; i++) begin
      s = sync_i;
      tick();
      if (s) break;
    end
  endtask

  initial begin
    bit rv, mv, tv, prev_v;
    logic [11:0] prev_w;

    rst = 1; sync_i = 0; train_req = 1;
    idle_inputs();
    tick(); tick();
    check_val("rst_train", cout_train, 1'b1);
    check_val("rst_cmd", cout_command, 32'h0);
    check_val("rst_run_ready", run_ready, 1'b0);
    check_val("rst_msg_ready", msg_ready, 1'b0);
    check_val("rst_ovf", trig_overflow, 1'b0);
    check_val("rst_count", trig_count, 16'h0);
    rst = 0;
    tick();

    bring_up();

    // single trigger, one cycle after push
    trig = 1; trig_word = 12'h001;
    exp_q.push_back(32'h0001_0000);
    tick();
    trig = 0;
    check_val("push_edge_cmd", cout_command, 32'h0);
    tick();
    exp_count++;
    check_val("trig1_cmd", cout_command, exp_q.pop_front());
    check_val("trig1_count", trig_count, exp_count);

    // all three fields on one edge
    trig = 1; trig_word = 12'h123;
    tick();
    idle_inputs();
    run_valid = 1; run_cmd = 4'hA; msg_valid = 1; msg_data = 16'hBEEF;
    exp_q.push_back(32'hA123_BEEF);
    tick();
    idle_inputs();
    exp_count++;
    check_val("merge_cmd", cout_command, exp_q.pop_front());

    // random handshakes and triggers; FIFO never holds more than one entry
    prev_v = 0; prev_w = '0;
    for (int i = 0; i < 12; i++) begin
      rv = (i == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      mv = 1'($urandom_range(0, 1));
      tv = 1'($urandom_range(0, 1));
      run_valid = rv; run_cmd = (i == 3) ? 4'h0 : 4'($urandom_range(0, 15));
      msg_valid = mv; msg_data = 16'($urandom_range(0, 65535));
      trig = tv; trig_word = (i == 5) ? 12'h0 : 12'($urandom_range(1, 4095));
      exp_q.push_back({rv ? run_cmd : 4'h0, prev_v ? prev_w : 12'h0, mv ? msg_data : 16'h0});
      if (prev_v) exp_count++;
      tick();
      check_val("rand_cmd", cout_command, exp_q.pop_front());
      prev_v = tv; prev_w = trig_word;
    end
    idle_inputs();
    exp_q.push_back({4'h0, prev_v ? prev_w : 12'h0, 16'h0});
    if (prev_v) exp_count++;
    tick();
    check_val("rand_tail_cmd", cout_command, exp_q.pop_front());
    check_val("rand_count", trig_count, exp_count);

    // train request off-sync is ignored until the next sync edge
    for (int i = 0; i < 8 && sync_i; i++) tick();
    train_req = 1;
    tick();
    check_val("offsync_train", cout_train, 1'b0);
    check_val("offsync_ready", run_ready, 1'b1);
    wait_sync_edge();
    check_val("retrain_train", cout_train, 1'b1);
    check_val("retrain_run_ready", run_ready, 1'b0);
    check_val("retrain_msg_ready", msg_ready, 1'b0);

    // overflow in TRAIN, then drain after guard
    for (int i = 1; i <= 5; i++) begin
      trig = 1; trig_word = 12'(i);
      if (i <= 4) exp_q.push_back({4'h0, 12'(i), 16'h0});
      tick();
      if (i == 4) check_val("ovf_not_yet", trig_overflow, 1'b0);
    end
    check_val("ovf_set", trig_overflow, 1'b1);
    trig = 1; trig_word = 12'h006; ovf_clr = 1;
    tick();
    idle_inputs();
    check_val("ovf_prio", trig_overflow, 1'b1);
    bring_up();
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_count++;
      check_val("drain_cmd", cout_command, exp_q.pop_front());
    end
    tick();
    check_val("drain_done_cmd", cout_command, 32'h0);
    check_val("drain_count", trig_count, exp_count);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    check_val("ovf_clr", trig_overflow, 1'b0);

    // reset in RUN with three triggers queued
    train_req = 1;
    wait_sync_edge();
    for (int i = 7; i <= 9; i++) begin
      trig = 1; trig_word = 12'(i);
      tick();
    end
    idle_inputs();
    bring_up();
    rst = 1;
    #2;
    check_val("mrst_train", cout_train, 1'b1);
    check_val("mrst_cmd", cout_command, 32'h0);
    check_val("mrst_ready", run_ready, 1'b0);
    check_val("mrst_count", trig_count, 16'h0);
    check_val("mrst_ovf", trig_overflow, 1'b0);
    tick(); tick();
    rst = 0;
    exp_count = '0;
    bring_up();
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("no_stale_cmd", cout_command, 32'h0);
    end
    check_val("no_stale_count", trig_count, exp_count);
    check_val("sb_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/turfio_cout_cmdgen.md
TURFIO_COUT_CMDGEN -- requirements
Module: turfio_cout_cmdgen

Interface
REQ-001 Parameter: TRIG_FIFO_DEPTH, 4, trigger FIFO entries (power of 2, 2..16).
REQ-002 Parameter: GUARD_WORDS, 2, idle command words after training exit before any request is serviced (1..15).
REQ-003 if_clk_i  in  1  sole clock; every output is registered on its rising edge.
REQ-004 if_rst_i  in  1  asynchronous, active-high reset.
REQ-005 sync_i  in  1  one-cycle sync marker; the output word is phase-aligned to this marker.
REQ-006 train_req_i  in  1  level; 1 requests training mode.
REQ-007 trig_i  in  1  one-cycle trigger strobe.
REQ-008 trig_word_i  in  12  trigger field, sampled with trig_i.
REQ-009 run_valid_i / run_ready_o  in / out  1 / 1  run-command handshake.
REQ-010 run_cmd_i  in  4  run-command nibble.
REQ-011 msg_valid_i / msg_ready_o  in / out  1 / 1  message handshake.
REQ-012 msg_data_i  in  16  message payload.
REQ-013 ovf_clr_i  in  1  clears trig_overflow_o.
REQ-014 cout_command_o  out  32  {run[3:0], trig[11:0], msg[15:0]}; feeds the COUT serializer command input.
REQ-015 cout_train_o  out  1  feeds the COUT serializer train input.
REQ-016 trig_overflow_o  out  1  sticky; set when a trigger is dropped.
REQ-017 trig_count_o  out  16  number of triggers sent; wraps.

Function
REQ-018 FSM states: TRAIN, EXIT_WAIT, GUARD, RUN.
REQ-019 TRAIN: cout_train_o=1; cout_command_o=0; when train_req_i=0, go to EXIT_WAIT.
REQ-020 EXIT_WAIT: cout_train_o=1.
  - If train_req_i=1, return to TRAIN.
  - Else on the edge where sync_i=1, go to GUARD and drop cout_train_o; the drop is visible the cycle after that sync_i.
REQ-021 GUARD: cout_train_o=0; cout_command_o=0; counts GUARD_WORDS cycles, then goes to RUN.
REQ-022 RUN: train_req_i=1 sampled on a sync_i edge returns to TRAIN; train_req_i=1 is ignored on non-sync edges.
REQ-023 run_ready_o and msg_ready_o are 1 only in RUN; a handshake completes when valid&ready at an edge.
REQ-024 Each edge in RUN loads cout_command_o from the following fields, each zero if absent:
  - run field = run_cmd_i if the run handshake completes;
  - msg field = msg_data_i if the msg handshake completes;
  - trig field = FIFO head if the FIFO is non-empty, popping the head.
  Latency from accept edge to visible output is 1 cycle.
REQ-025 The trigger FIFO accepts trig_i in every state; a push at edge E with an empty FIFO in RUN appears on cout_command_o after edge E+1.
REQ-026 Simultaneous push and pop on a full FIFO: the push is accepted and the count is unchanged.
REQ-027 Push when full and no pop: the trigger is discarded and trig_overflow_o is set at that edge.
REQ-028 ovf_clr_i clears trig_overflow_o; a simultaneous overflow event takes priority and the flag stays 1.
REQ-029 trig_word_i=0 is a legal push but is sent as an all-zero field.
REQ-030 trig_count_o increments on each FIFO pop and wraps from 0xFFFF to 0.
REQ-031 Entering TRAIN from RUN keeps the FIFO contents; they drain after the next GUARD.
REQ-032 run_cmd_i=0 accepted via handshake produces a zero run field (no-op).

Reset
REQ-033 While if_rst_i=1 (asynchronously):
  - state = TRAIN; cout_train_o=1; cout_command_o=0;
  - run_ready_o=0; msg_ready_o=0;
  - FIFO emptied; trig_overflow_o=0; trig_count_o=0.
REQ-034 Reset asserted mid-RUN discards queued triggers and any word in flight; after release the block restarts in TRAIN.

Verification
REQ-035 Reset then train_req_i=0 with sync_i every 8 cycles:
  - cout_train_o falls exactly 1 cycle after the first sync_i;
  - then 2 zero words;
  - run_ready_o rises on the 3rd cycle after the drop.
REQ-036 In RUN, trig_i with 0x001, one cycle -> next cycle cout_command_o=0x00010000 and trig_count_o=1.
REQ-037 Same edge in RUN: run_cmd_i=0xA, trig 0x123, msg 0xBEEF all accepted -> cout_command_o=0xA123BEEF.
REQ-038 While in TRAIN, pulse trig_i 5 times (values 1..5) -> FIFO holds 1..4 and trig_overflow_o=1; after GUARD, 4 consecutive trig fields 1,2,3,4; ovf_clr_i -> flag 0.
REQ-039 Raise train_req_i in RUN off-sync -> no change until the next sync_i; then cout_train_o=1 the following cycle and ready outputs fall.
REQ-040 Assert if_rst_i mid-RUN with 3 triggers queued -> outputs at reset values immediately; after release no queued trigger ever appears.
